// File: rtl/burst_wr_ctrl_pkg.sv
// Shared types and defaults for the MarginSampling512 burst write sequencer.
package burst_wr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DEF_DEPTH  = 512;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_INCR   = 1;

   // Beats needed to fill one buffer at the given stride.
   function automatic int nbeats(input int depth, input int incr);
      return depth / incr;
   endfunction

endpackage

// File: rtl/burst_wr_ctrl_if.sv
// Score stream in and RAM write port out of the burst write sequencer.
interface burst_wr_ctrl_if
   import burst_wr_ctrl_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DATA_W = DEF_DATA_W
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // Upstream producer / RAM observer side.
   modport master (
      output s_valid, s_data,
      input  s_ready, wr_en, wr_addr, wr_data
   );

   // Sequencer side.
   modport slave (
      input  s_valid, s_data,
      output s_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/burst_addr_gen.sv
// Strided write-address counter with sync clear and last-beat flag.
module burst_addr_gen #(
   parameter  int DEPTH  = 512,
   parameter  int INCR   = 1,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   output logic [ADDR_W-1:0] addr,
   output logic              tc
);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(INCR);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - INCR);

   logic [ADDR_W-1:0] addr_r;

   // Address register; wraps naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_r <= '0;
      end else if (clr) begin
         addr_r <= '0;
      end else if (en) begin
         addr_r <= addr_r + STRIDE;
      end else begin
         addr_r <= addr_r;
      end
   end

   assign addr = addr_r;
   assign tc   = (addr_r == LAST);

endmodule

// File: rtl/burst_wr_ctrl.sv
// Burst write sequencer: fills one DEPTH-entry buffer from a valid/ready stream.
// Optional stall counter port enabled by BURST_WR_STALL_CNT_EN.
module burst_wr_ctrl
   import burst_wr_ctrl_pkg::*;
#(
   parameter  int DEPTH  = DEF_DEPTH,
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int INCR   = DEF_INCR,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   burst_wr_ctrl_if.slave  bus,
   output logic            busy,
   output logic            done,
   output logic [ADDR_W:0] wr_cnt
`ifdef BURST_WR_STALL_CNT_EN
   ,
   output logic [15:0]     stall_cnt
`endif
);
   localparam int              NBEATS  = nbeats(DEPTH, INCR);
   localparam int              CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBEATS);

   state_e            state_r, state_s;
   logic              ready_s, accept_s, arm_s, step_s, tc_s;
   logic [ADDR_W-1:0] addr_s;
   logic              wr_en_r, busy_r, done_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic [CNT_W-1:0]  cnt_r;

   assign ready_s  = (state_r == WRITE);
   assign accept_s = bus.s_valid & ready_s;

   burst_addr_gen #(
      .DEPTH (DEPTH),
      .INCR  (INCR)
   ) u_addr_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (arm_s),
      .en    (step_s),
      .addr  (addr_s),
      .tc    (tc_s)
   );

   // Next-state decode; abort outranks a same-cycle accept.
   always_comb begin
      state_s = state_r;
      arm_s   = 1'b0;
      step_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = WRITE;
               arm_s   = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         WRITE: begin
            if (abort) begin
               state_s = IDLE;
            end else if (accept_s) begin
               step_s  = 1'b1;
               state_s = tc_s ? DONE : WRITE;
            end else begin
               state_s = WRITE;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State and registered outputs; one-cycle write latency from accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         wr_en_r   <= 1'b0;
         wr_addr_r <= '0;
         wr_data_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         cnt_r     <= '0;
      end else begin
         state_r <= state_s;
         wr_en_r <= step_s;
         busy_r  <= (state_s == WRITE);
         done_r  <= (state_s == DONE);
         if (step_s) begin
            wr_addr_r <= addr_s;
            wr_data_r <= bus.s_data;
         end else begin
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
         end
         if (arm_s) begin
            cnt_r <= '0;
         end else if (step_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign bus.s_ready = ready_s;
   assign bus.wr_en   = wr_en_r;
   assign bus.wr_addr = wr_addr_r;
   assign bus.wr_data = wr_data_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign wr_cnt      = cnt_r;

`ifdef BURST_WR_STALL_CNT_EN
   logic [15:0] stall_r;

   // Idle-input cycles while writing; frozen outside WRITE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_r <= 16'h0000;
      end else if (arm_s) begin
         stall_r <= 16'h0000;
      end else if (ready_s && !bus.s_valid && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'h0001;
      end else begin
         stall_r <= stall_r;
      end
   end

   assign stall_cnt = stall_r;
`endif

endmodule

// File: tb/tb_burst_wr_ctrl.sv
// Self-checking bench: vector table on a DEPTH=16/INCR=4 instance, sequences on DEPTH=512.
module tb_burst_wr_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
   logic busy_a, done_a, busy_b, done_b;
   logic [9:0] cnt_a;
   logic [4:0] cnt_b;
`ifdef BURST_WR_STALL_CNT_EN
   logic [15:0] stall_a, stall_b;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   burst_wr_ctrl_if #(.DEPTH(512), .DATA_W(16)) bus_a ();
   burst_wr_ctrl_if #(.DEPTH(16),  .DATA_W(16)) bus_b ();

   burst_wr_ctrl #(.DEPTH(512), .DATA_W(16), .INCR(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .bus(bus_a),
      .busy(busy_a), .done(done_a), .wr_cnt(cnt_a)
`ifdef BURST_WR_STALL_CNT_EN
      , .stall_cnt(stall_a)
`endif
   );

   burst_wr_ctrl #(.DEPTH(16), .DATA_W(16), .INCR(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .bus(bus_b),
      .busy(busy_b), .done(done_b), .wr_cnt(cnt_b)
`ifdef BURST_WR_STALL_CNT_EN
      , .stall_cnt(stall_b)
`endif
   );

   typedef struct {
      logic        start;
      logic        abort;
      logic        valid;
      logic [15:0] data;
      logic        ready;
      logic        wr_en;
      logic [3:0]  addr;
      logic [15:0] wdata;
      logic        busy;
      logic        done;
      logic [4:0]  cnt;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int beat;
      int cyc;
      bus_a.s_valid = 1'b0; bus_a.s_data = 16'h0000;
      bus_b.s_valid = 1'b0; bus_b.s_data = 16'h0000;

      //              st    ab    v     data      rdy   we    addr  wdata     busy  done  cnt
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 5'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h00A1, 1'b1, 1'b1, 4'd0,  16'h00A1, 1'b1, 1'b0, 5'd1};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0BAD, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 5'd1};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h00B2, 1'b1, 1'b1, 4'd4,  16'h00B2, 1'b1, 1'b0, 5'd2};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h00C3, 1'b1, 1'b1, 4'd8,  16'h00C3, 1'b1, 1'b0, 5'd3};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h00D4, 1'b0, 1'b1, 4'd12, 16'h00D4, 1'b0, 1'b1, 5'd4};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h00EE, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 5'd4};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h00EF, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 5'd4};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 5'd0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h00E5, 1'b1, 1'b1, 4'd0,  16'h00E5, 1'b1, 1'b0, 5'd1};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 16'h00F6, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 5'd1};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 5'd0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h0077, 1'b1, 1'b1, 4'd0,  16'h0077, 1'b1, 1'b0, 5'd1};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h0088, 1'b1, 1'b1, 4'd4,  16'h0088, 1'b1, 1'b0, 5'd2};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b1, 4'd8,  16'h0099, 1'b1, 1'b0, 5'd3};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h00AA, 1'b0, 1'b1, 4'd12, 16'h00AA, 1'b0, 1'b1, 5'd4};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 5'd4};

      // Reset state.
      tick();
      tick();
      chk("rst_ready", {31'd0, bus_a.s_ready}, 32'd0);
      chk("rst_wr_en", {31'd0, bus_a.wr_en}, 32'd0);
      chk("rst_addr",  {23'd0, bus_a.wr_addr}, 32'd0);
      chk("rst_data",  {16'd0, bus_a.wr_data}, 32'd0);
      chk("rst_busy",  {31'd0, busy_a}, 32'd0);
      chk("rst_done",  {31'd0, done_a}, 32'd0);
      chk("rst_cnt",   {22'd0, cnt_a}, 32'd0);
      chk("rst_b_cnt", {27'd0, cnt_b}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Stride 4 / depth 16: vector table incl. ignored start, abort, restart.
      for (int i = 0; i < 17; i++) begin
         start_b = vecs[i].start;
         abort_b = vecs[i].abort;
         bus_b.s_valid = vecs[i].valid;
         bus_b.s_data  = vecs[i].data;
         tick();
         chk($sformatf("vec%0d_ready", i), {31'd0, bus_b.s_ready}, {31'd0, vecs[i].ready});
         chk($sformatf("vec%0d_wr_en", i), {31'd0, bus_b.wr_en}, {31'd0, vecs[i].wr_en});
         chk($sformatf("vec%0d_busy", i),  {31'd0, busy_b}, {31'd0, vecs[i].busy});
         chk($sformatf("vec%0d_done", i),  {31'd0, done_b}, {31'd0, vecs[i].done});
         chk($sformatf("vec%0d_cnt", i),   {27'd0, cnt_b}, {27'd0, vecs[i].cnt});
         if (vecs[i].wr_en) begin
            chk($sformatf("vec%0d_addr", i),  {28'd0, bus_b.wr_addr}, {28'd0, vecs[i].addr});
            chk($sformatf("vec%0d_wdata", i), {16'd0, bus_b.wr_data}, {16'd0, vecs[i].wdata});
         end
      end
      start_b = 1'b0; abort_b = 1'b0; bus_b.s_valid = 1'b0;

      // Full burst, continuous valid.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("full_busy0", {31'd0, busy_a}, 32'd1);
      chk("full_cnt0",  {22'd0, cnt_a}, 32'd0);
      for (int i = 0; i < 512; i++) begin
         bus_a.s_valid = 1'b1;
         bus_a.s_data  = 16'(i);
         tick();
         chk("full_wr_en", {31'd0, bus_a.wr_en}, 32'd1);
         chk("full_addr",  {23'd0, bus_a.wr_addr}, i);
         chk("full_data",  {16'd0, bus_a.wr_data}, i);
         chk("full_done",  {31'd0, done_a}, (i == 511) ? 32'd1 : 32'd0);
         chk("full_cnt",   {22'd0, cnt_a}, i + 1);
      end
      bus_a.s_valid = 1'b0;
      tick();
      chk("full_after_busy",  {31'd0, busy_a}, 32'd0);
      chk("full_after_done",  {31'd0, done_a}, 32'd0);
      chk("full_after_wr_en", {31'd0, bus_a.wr_en}, 32'd0);
      chk("full_after_ready", {31'd0, bus_a.s_ready}, 32'd0);
      chk("full_after_cnt",   {22'd0, cnt_a}, 32'd512);

      // Backpressure: valid toggles every cycle.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      beat = 0;
      cyc  = 0;
      while (beat < 512 && cyc < 4000) begin
         bus_a.s_valid = (cyc % 2 == 0);
         bus_a.s_data  = 16'(beat);
         tick();
         if (cyc % 2 == 0) begin
            chk("bp_wr_en", {31'd0, bus_a.wr_en}, 32'd1);
            chk("bp_addr",  {23'd0, bus_a.wr_addr}, beat);
            chk("bp_data",  {16'd0, bus_a.wr_data}, beat);
            chk("bp_done",  {31'd0, done_a}, (beat == 511) ? 32'd1 : 32'd0);
            beat++;
         end else begin
            chk("bp_gap_wr_en", {31'd0, bus_a.wr_en}, 32'd0);
            chk("bp_gap_done",  {31'd0, done_a}, 32'd0);
         end
         cyc++;
      end
      chk("bp_beats", beat, 32'd512);
`ifdef BURST_WR_STALL_CNT_EN
      chk("bp_stall", {16'd0, stall_a}, 32'd511);
`endif
      bus_a.s_valid = 1'b0;
      tick();
      chk("bp_after_busy", {31'd0, busy_a}, 32'd0);
`ifdef BURST_WR_STALL_CNT_EN
      chk("bp_stall_hold", {16'd0, stall_a}, 32'd511);
`endif

      // Abort after 10 accepts with valid still high.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus_a.s_valid = 1'b1;
         bus_a.s_data  = 16'(i);
         tick();
      end
      abort_a = 1'b1;
      bus_a.s_data = 16'd10;
      tick();
      abort_a = 1'b0;
      bus_a.s_valid = 1'b0;
      chk("abort_wr_en", {31'd0, bus_a.wr_en}, 32'd0);
      chk("abort_busy",  {31'd0, busy_a}, 32'd0);
      chk("abort_ready", {31'd0, bus_a.s_ready}, 32'd0);
      chk("abort_done",  {31'd0, done_a}, 32'd0);
      chk("abort_cnt",   {22'd0, cnt_a}, 32'd10);
      tick();
      chk("abort_idle_done", {31'd0, done_a}, 32'd0);
      chk("abort_idle_cnt",  {22'd0, cnt_a}, 32'd10);

      // Restart from address 0, then reset at beat 200.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("restart_cnt", {22'd0, cnt_a}, 32'd0);
      for (int i = 0; i < 200; i++) begin
         bus_a.s_valid = 1'b1;
         bus_a.s_data  = 16'(16'h0100 + i);
         tick();
         chk("restart_addr", {23'd0, bus_a.wr_addr}, i);
      end
      rst_n = 1'b0;
      bus_a.s_data = 16'hBEEF;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_ready", {31'd0, bus_a.s_ready}, 32'd0);
      chk("mid_rst_wr_en", {31'd0, bus_a.wr_en}, 32'd0);
      chk("mid_rst_addr",  {23'd0, bus_a.wr_addr}, 32'd0);
      chk("mid_rst_data",  {16'd0, bus_a.wr_data}, 32'd0);
      chk("mid_rst_busy",  {31'd0, busy_a}, 32'd0);
      chk("mid_rst_done",  {31'd0, done_a}, 32'd0);
      chk("mid_rst_cnt",   {22'd0, cnt_a}, 32'd0);
`ifdef BURST_WR_STALL_CNT_EN
      chk("mid_rst_stall", {16'd0, stall_a}, 32'd0);
`endif
      tick();
      chk("post_rst_ready", {31'd0, bus_a.s_ready}, 32'd0);
      chk("post_rst_wr_en", {31'd0, bus_a.wr_en}, 32'd0);
      chk("post_rst_busy",  {31'd0, busy_a}, 32'd0);
      bus_a.s_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
